// File: rtl/bcd_axis_scheduler_if.sv
// Handshake/bus bundle for bcd_axis_scheduler.
// The master side (display/sensor path) drives the request and the raw axis
// bytes. The slave side (the scheduler) returns the BCD results and status.
interface bcd_axis_scheduler_if #(
  parameter int DATA_W = 8
);
  logic              sample_req;
  logic [DATA_W-1:0] xout;
  logic [DATA_W-1:0] yout;
  logic [DATA_W-1:0] zout;
  logic [7:0]        x_data_bcd;
  logic [7:0]        y_data_bcd;
  logic [7:0]        z_data_bcd;
  logic [2:0]        ovf;
  logic              busy;
  logic              data_valid;

  modport master (
    output sample_req, xout, yout, zout,
    input  x_data_bcd, y_data_bcd, z_data_bcd, ovf, busy, data_valid
  );

  modport slave (
    input  sample_req, xout, yout, zout,
    output x_data_bcd, y_data_bcd, z_data_bcd, ovf, busy, data_valid
  );
endinterface

// File: rtl/bcd_axis_scheduler.sv
// bcd_axis_scheduler
// A single serial double-dabble engine is time-shared across the X, Y and Z
// axis bytes. A request snapshots all three axes. They are then converted in
// the order X, Y, Z into staging registers, and all three BCD results plus
// the saturation flags are committed to the outputs on one edge, so the
// display never sees a mix of old and new samples.
//
// Optional feature: define PENDING_REQ_EN to keep a one-deep pending request
// that is captured while busy. A pending request restarts conversion directly
// at the commit edge. When the macro is undefined, requests made while busy
// are dropped.
module bcd_axis_scheduler #(
  parameter int         DATA_W  = 8,
  parameter logic [7:0] SAT_BCD = 8'h99
) (
  input logic                 clk,
  input logic                 rst,
  bcd_axis_scheduler_if.slave bus
);

  localparam int SCR_W = DATA_W + 12;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STORE,
    S_COMMIT
  } state_t;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift.
  function automatic logic [SCR_W-1:0] dd_step(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[DATA_W + 4*k +: 4] >= 4'd5) begin
        t[DATA_W + 4*k +: 4] = t[DATA_W + 4*k +: 4] + 4'd3;
      end
    end
    return {t[SCR_W-2:0], 1'b0};
  endfunction

  // Collapse a 3-digit BCD value to two digits, saturating anything >= 100.
  // Bit 8 of the result is the overflow flag.
  function automatic logic [8:0] sat_bcd(input logic [11:0] d);
    if (d[11:8] != 4'd0) begin
      return {1'b1, SAT_BCD};
    end
    return {1'b0, d[7:0]};
  endfunction

  state_t            r_state;
  logic [1:0]        r_axis;
  logic [CNT_W-1:0]  r_cnt;
  logic [SCR_W-1:0]  r_scr;
  logic [DATA_W-1:0] r_snap_x;
  logic [DATA_W-1:0] r_snap_y;
  logic [DATA_W-1:0] r_snap_z;
  logic [7:0]        r_res_x;
  logic [7:0]        r_res_y;
  logic [7:0]        r_res_z;
  logic [2:0]        r_ovf_stg;
  logic [7:0]        r_x_bcd;
  logic [7:0]        r_y_bcd;
  logic [7:0]        r_z_bcd;
  logic [2:0]        r_ovf;
  logic              r_busy;
  logic              r_dv;
`ifdef PENDING_REQ_EN
  logic              r_pending;
`endif

  logic [DATA_W-1:0] w_snap_sel;
  logic [8:0]        w_sat;

  // Select the snapshot of the axis currently being converted.
  always_comb begin
    w_snap_sel = r_snap_x;
    case (r_axis)
      2'd0:    w_snap_sel = r_snap_x;
      2'd1:    w_snap_sel = r_snap_y;
      default: w_snap_sel = r_snap_z;
    endcase
  end

  assign w_sat = sat_bcd(r_scr[SCR_W-1 -: 12]);

  // Scheduler FSM. This block holds the engine datapath, the staging
  // registers, and the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_axis    <= 2'd0;
      r_cnt     <= '0;
      r_scr     <= '0;
      r_snap_x  <= '0;
      r_snap_y  <= '0;
      r_snap_z  <= '0;
      r_res_x   <= 8'h00;
      r_res_y   <= 8'h00;
      r_res_z   <= 8'h00;
      r_ovf_stg <= 3'b000;
      r_x_bcd   <= 8'h00;
      r_y_bcd   <= 8'h00;
      r_z_bcd   <= 8'h00;
      r_ovf     <= 3'b000;
      r_busy    <= 1'b0;
      r_dv      <= 1'b0;
`ifdef PENDING_REQ_EN
      r_pending <= 1'b0;
`endif
    end else begin
      r_dv <= 1'b0;
`ifdef PENDING_REQ_EN
      // Requests arriving mid-conversion collapse into one pending flag.
      // A request seen in the commit cycle is served directly below.
      if (r_busy && bus.sample_req && (r_state != S_COMMIT)) begin
        r_pending <= 1'b1;
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (bus.sample_req) begin
            r_snap_x <= bus.xout;
            r_snap_y <= bus.yout;
            r_snap_z <= bus.zout;
            r_axis   <= 2'd0;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_scr   <= {12'h000, w_snap_sel};
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_scr <= dd_step(r_scr);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_STORE;
          end
        end
        S_STORE: begin
          case (r_axis)
            2'd0: begin
              r_res_x      <= w_sat[7:0];
              r_ovf_stg[0] <= w_sat[8];
            end
            2'd1: begin
              r_res_y      <= w_sat[7:0];
              r_ovf_stg[1] <= w_sat[8];
            end
            default: begin
              r_res_z      <= w_sat[7:0];
              r_ovf_stg[2] <= w_sat[8];
            end
          endcase
          if (r_axis < 2'd2) begin
            r_axis  <= r_axis + 2'd1;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          // All three results and flags become visible on the same edge.
          r_x_bcd <= r_res_x;
          r_y_bcd <= r_res_y;
          r_z_bcd <= r_res_z;
          r_ovf   <= r_ovf_stg;
          r_dv    <= 1'b1;
`ifdef PENDING_REQ_EN
          if (r_pending || bus.sample_req) begin
            r_snap_x  <= bus.xout;
            r_snap_y  <= bus.yout;
            r_snap_z  <= bus.zout;
            r_axis    <= 2'd0;
            r_pending <= 1'b0;
            r_state   <= S_LOAD;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
`else
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x_data_bcd = r_x_bcd;
  assign bus.y_data_bcd = r_y_bcd;
  assign bus.z_data_bcd = r_z_bcd;
  assign bus.ovf        = r_ovf;
  assign bus.busy       = r_busy;
  assign bus.data_valid = r_dv;

endmodule

// File: tb/tb_bcd_axis_scheduler.sv
// Testbench for bcd_axis_scheduler: directed steps plus randomized axis
// values, compared cycle by cycle against a transaction-level reference model.
module tb_bcd_axis_scheduler;

  localparam int DATA_W = 8;
`ifdef PENDING_REQ_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif
  localparam int LAT    = 31;
  localparam int PERIOD = PEND ? 31 : 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_axis_scheduler_if #(.DATA_W(DATA_W)) bus ();

  bcd_axis_scheduler #(.DATA_W(DATA_W), .SAT_BCD(8'h99)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state.
  bit         m_busy, m_pend, m_dv;
  int         m_left;
  logic [7:0] m_x, m_y, m_z;
  logic [2:0] m_ovf;
  int         qx[$], qy[$], qz[$];

  function automatic logic [7:0] ref_bcd(int v);
    if (v > 99) return 8'h99;
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_pend = 0; m_dv = 0; m_left = 0;
    m_x = 0; m_y = 0; m_z = 0; m_ovf = 0;
    qx.delete(); qy.delete(); qz.delete();
  endtask

  task automatic model_push();
    qx.push_back(int'(bus.xout));
    qy.push_back(int'(bus.yout));
    qz.push_back(int'(bus.zout));
    m_left = LAT;
  endtask

  // One clock edge at transaction level: requests are accepted when idle,
  // and a result lands LAT edges later.
  task automatic model_edge(input bit r);
    int vx, vy, vz;
    m_dv = 0;
    if (!m_busy) begin
      if (r) begin
        model_push();
        m_busy = 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        vx = qx.pop_front(); vy = qy.pop_front(); vz = qz.pop_front();
        m_x = ref_bcd(vx); m_y = ref_bcd(vy); m_z = ref_bcd(vz);
        m_ovf = {vz > 99, vy > 99, vx > 99};
        m_dv = 1;
        if (PEND && (m_pend || r)) begin
          model_push();
          m_pend = 0;
        end else begin
          m_busy = 0;
        end
      end else if (PEND && r) begin
        m_pend = 1;
      end
    end
  endtask

  task automatic set_in(input int x, input int y, input int z);
    bus.xout = 8'(x); bus.yout = 8'(y); bus.zout = 8'(z);
  endtask

  task automatic set_rand();
    set_in($urandom_range(0, 255), $urandom_range(0, 120), $urandom_range(0, 99));
  endtask

  // Drive the request, take one edge, and compare every output with the model.
  task automatic cycle(input bit r);
    bus.sample_req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    cyc++;
    check("data_valid", 32'(bus.data_valid), 32'(m_dv));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("outputs", {5'd0, bus.x_data_bcd, bus.y_data_bcd, bus.z_data_bcd, bus.ovf},
          {5'd0, m_x, m_y, m_z, m_ovf});
  endtask

  task automatic wait_dv(output int w);
    bit got;
    got = 0;
    w = 0;
    while (w < 100 && !got) begin
      cycle(1'b0);
      w++;
      if (bus.data_valid === 1'b1) got = 1;
    end
    check("dv_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int w, cnt, last, start;
    bus.sample_req = 1'b0;
    set_in(0, 0, 0);
    model_reset();

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst_x", 32'(bus.x_data_bcd), 32'h0);
    check("rst_y", 32'(bus.y_data_bcd), 32'h0);
    check("rst_z", 32'(bus.z_data_bcd), 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_dv", 32'(bus.data_valid), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b0);

    // Basic conversion with latency
    set_in(42, 7, 99);
    cycle(1'b1);
    check("basic_busy_after_accept", 32'(bus.busy), 32'd1);
    wait_dv(w);
    check("basic_latency", 32'(w), 32'(LAT));
    check("basic_x", 32'(bus.x_data_bcd), 32'h42);
    check("basic_y", 32'(bus.y_data_bcd), 32'h07);
    check("basic_z", 32'(bus.z_data_bcd), 32'h99);
    check("basic_ovf", 32'(bus.ovf), 32'b000);
    check("basic_busy_low", 32'(bus.busy), 32'd0);
    cycle(1'b0);
    check("basic_dv_one_cycle", 32'(bus.data_valid), 32'd0);

    // Saturation
    set_in(100, 255, 0);
    cycle(1'b1);
    wait_dv(w);
    check("sat_x", 32'(bus.x_data_bcd), 32'h99);
    check("sat_y", 32'(bus.y_data_bcd), 32'h99);
    check("sat_z", 32'(bus.z_data_bcd), 32'h00);
    check("sat_ovf", 32'(bus.ovf), 32'b011);
    cycle(1'b0);

    // Snapshot coherence
    set_in(12, 34, 56);
    cycle(1'b1);
    set_in(88, 34, 56);
    wait_dv(w);
    check("snap_first", 32'(bus.x_data_bcd), 32'h12);
    cycle(1'b1);
    wait_dv(w);
    check("snap_second", 32'(bus.x_data_bcd), 32'h88);
    cycle(1'b0);

    // Request while busy
    set_rand();
    cycle(1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0);
    set_rand();
    cycle(1'b1);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0);
      if (bus.data_valid === 1'b1) cnt++;
    end
    check("busy_req_dv_count", 32'(cnt), PEND ? 32'd2 : 32'd1);

    // Reset mid-operation
    set_in(55, 66, 77);
    cycle(1'b1);
    for (int i = 0; i < 14; i++) cycle(1'b0);
    rst = 1'b1;
    #1;
    check("midrst_x", 32'(bus.x_data_bcd), 32'h0);
    check("midrst_y", 32'(bus.y_data_bcd), 32'h0);
    check("midrst_z", 32'(bus.z_data_bcd), 32'h0);
    check("midrst_ovf", 32'(bus.ovf), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_dv", 32'(bus.data_valid), 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0);
      if (bus.data_valid === 1'b1) cnt++;
    end
    check("midrst_no_dv", 32'(cnt), 32'd0);
    set_in(9, 10, 99);
    cycle(1'b1);
    wait_dv(w);
    check("post_rst_latency", 32'(w), 32'(LAT));
    check("post_rst_out", {8'd0, bus.x_data_bcd, bus.y_data_bcd, bus.z_data_bcd},
          32'h00091099);

    // Randomized single conversions
    for (int n = 0; n < 8; n++) begin
      set_rand();
      cycle(1'b1);
      wait_dv(w);
      check("rand_latency", 32'(w), 32'(LAT));
      cycle(1'b0);
    end

    // Back-to-back with request held high
    cnt = 0;
    last = -1;
    start = cyc;
    for (int i = 0; i < 150; i++) begin
      if (i < 70) set_rand();
      cycle(i < 70);
      if (bus.data_valid === 1'b1) begin
        if (last >= 0) check("b2b_spacing", 32'(cyc - last), 32'(PERIOD));
        else check("b2b_first", 32'(cyc - start - 1), 32'(LAT));
        last = cyc;
        cnt++;
      end
    end
    check("b2b_count", 32'(cnt), PEND ? 32'd4 : 32'd3);
    check("b2b_idle_end", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
